// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

   typedef logic [4:0]  u5;
   typedef logic [63:0] u64;

   localparam int REG_NUM       = 32;
   localparam int WB_FIFO_DEPTH = 4;

   // One pending register-file write: destination index and result.
   typedef struct packed {
      u5  rd;
      u64 data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO buffering long-unit writebacks.
// The caller guarantees push only when not full and pop only when not empty.
module regfile_wb_arbiter_wb_fifo
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = WB_FIFO_DEPTH,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  wb_req_t       push_data,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output wb_req_t       head
);

   wb_req_t       mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Pointer and occupancy bookkeeping; DEPTH is a power of two, so pointers wrap on overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Entry storage; contents are don't-care until written, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline and long-unit writebacks onto the single register-file write port,
// and keeps the busy scoreboard of outstanding long-op destinations.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        pipe_valid,
   input  logic [4:0]                  pipe_rd,
   input  logic [63:0]                 pipe_data,
   input  logic                        lu_valid,
   output logic                        lu_ready,
   input  logic [4:0]                  lu_rd,
   input  logic [63:0]                 lu_data,
   input  logic                        iss_valid,
   input  logic [4:0]                  iss_rd,
   output logic [4:0]                  reg_w,
   output logic [63:0]                 w_data,
   output logic                        reg_w_ctrl,
   output logic [REG_NUM-1:0]          busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   wb_req_t            head;
   wb_req_t            lu_req;
   wb_req_t            sel;
   logic               sel_valid;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic [REG_NUM-1:0] busy_nxt;

   // lu_ready looks only at occupancy, so a full FIFO refuses even while it pops.
   assign lu_ready = !full;
   assign push     = lu_valid && !full;
   assign pop      = !pipe_valid && !empty;
   assign lu_req   = '{rd: lu_rd, data: lu_data};

   regfile_wb_arbiter_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (lu_req),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .count     (fifo_count),
      .head      (head)
   );

   // Strict priority: pipeline first, then FIFO head, else nothing.
   always_comb begin
      sel       = head;
      sel_valid = 1'b0;
      if (pipe_valid) begin
         sel.rd    = pipe_rd;
         sel.data  = pipe_data;
         sel_valid = 1'b1;
      end else if (!empty) begin
         sel_valid = 1'b1;
      end
   end

   // Registered write port; x0 entries load index/data but never enable the write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_w      <= '0;
         w_data     <= '0;
         reg_w_ctrl <= 1'b0;
      end else if (sel_valid) begin
         reg_w      <= sel.rd;
         w_data     <= sel.data;
         reg_w_ctrl <= (sel.rd != '0);
      end else begin
         reg_w_ctrl <= 1'b0;
      end
   end

   // Scoreboard next state: pop clears, issue sets afterwards so it wins on a collision.
   always_comb begin
      busy_nxt = busy;
      if (pop) busy_nxt[head.rd] = 1'b0;
      if (iss_valid && iss_rd != '0) busy_nxt[iss_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, directed corner sequences,
// and a random soak against a queue-based reference model.
module tb_regfile_wb_arbiter;
   import regfile_wb_arbiter_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pipe_valid, lu_valid, iss_valid;
   logic [4:0]  pipe_rd, lu_rd, iss_rd;
   logic [63:0] pipe_data, lu_data;
   logic        lu_ready, reg_w_ctrl;
   logic [4:0]  reg_w;
   logic [63:0] w_data;
   logic [31:0] busy;
   logic [2:0]  fifo_count;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .reg_w(reg_w), .w_data(w_data), .reg_w_ctrl(reg_w_ctrl),
      .busy(busy), .fifo_count(fifo_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   wb_req_t     q[$];
   logic [31:0] busy_m;
   logic [4:0]  rw_m;
   logic [63:0] wd_m;
   logic        wc_m;
   logic        hold_prev;
   logic [4:0]  prev_rd;
   logic [63:0] prev_data;

   typedef struct {
      logic        pv;
      logic [4:0]  rd;
      logic [63:0] data;
      logic        e_ctrl;
      logic [4:0]  e_rw;
      logic [63:0] e_data;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      busy_m    = '0;
      rw_m      = '0;
      wd_m      = '0;
      wc_m      = 1'b0;
      hold_prev = 1'b0;
   endtask

   task automatic idle_inputs();
      pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
      lu_valid = 0; lu_rd = 0; lu_data = 0;
      iss_valid = 0; iss_rd = 0;
   endtask

   // One clock: legality and pre-edge checks, model update, then post-edge compare.
   task automatic cycle();
      logic    ready_m, popping;
      wb_req_t e;
      ready_m = (q.size() != DEPTH);
      popping = !pipe_valid && (q.size() > 0);
      chk("lu_ready_pre", lu_ready, ready_m);
      chk("fifo_count_pre", fifo_count, 64'(q.size()));
      if (hold_prev) begin
         checks++;
         if (!(lu_valid && lu_rd == prev_rd && lu_data == prev_data)) begin
            errors++;
            $display("FAIL illegal_lu_drop: actual valid=%0b rd=%0d required held rd=%0d", lu_valid, lu_rd, prev_rd);
         end
      end
      if (iss_valid && iss_rd != 0) begin
         checks++;
         if (busy_m[iss_rd] && !(popping && q[0].rd == iss_rd)) begin
            errors++;
            $display("FAIL illegal_iss: actual rd=%0d busy required not busy", iss_rd);
         end
      end
      if (pipe_valid) begin
         checks++;
         if (busy_m[pipe_rd]) begin
            errors++;
            $display("FAIL illegal_pipe: actual rd=%0d busy required not busy", pipe_rd);
         end
      end
      hold_prev = lu_valid && !ready_m;
      prev_rd   = lu_rd;
      prev_data = lu_data;
      if (pipe_valid) begin
         rw_m = pipe_rd; wd_m = pipe_data; wc_m = (pipe_rd != 0);
      end else if (q.size() > 0) begin
         e = q.pop_front();
         rw_m = e.rd; wd_m = e.data; wc_m = (e.rd != 0);
         busy_m[e.rd] = 1'b0;
      end else begin
         wc_m = 1'b0;
      end
      if (lu_valid && ready_m) q.push_back('{rd: lu_rd, data: lu_data});
      if (iss_valid && iss_rd != 0) busy_m[iss_rd] = 1'b1;
      @(posedge clk);
      #1;
      chk("reg_w_ctrl", reg_w_ctrl, wc_m);
      chk("reg_w", reg_w, rw_m);
      chk("w_data", w_data, wd_m);
      chk("busy", busy, busy_m);
      chk("fifo_count", fifo_count, 64'(q.size()));
      chk("lu_ready", lu_ready, q.size() != DEPTH);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_reg_w"}, reg_w, 0);
      chk({tag, "_w_data"}, w_data, 0);
      chk({tag, "_reg_w_ctrl"}, reg_w_ctrl, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_fifo_count"}, fifo_count, 0);
      chk({tag, "_lu_ready"}, lu_ready, 1);
   endtask

   initial begin
      logic [4:0] pending[$];
      int         r;
      int         idx;

      vecs[0] = '{1'b1, 5'd5,  64'hDEAD_BEEF,          1'b1, 5'd5,  64'hDEAD_BEEF};
      vecs[1] = '{1'b1, 5'd0,  64'h1234,               1'b0, 5'd0,  64'h1234};
      vecs[2] = '{1'b0, 5'd9,  64'h5555,               1'b0, 5'd0,  64'h1234};
      vecs[3] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[4] = '{1'b1, 5'd12, 64'h0,                  1'b1, 5'd12, 64'h0};
      vecs[5] = '{1'b0, 5'd3,  64'hABCD,               1'b0, 5'd12, 64'h0};

      // Reset held for three cycles
      idle_inputs();
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Pipeline-only vectors
      foreach (vecs[i]) begin
         pipe_valid = vecs[i].pv; pipe_rd = vecs[i].rd; pipe_data = vecs[i].data;
         cycle();
         chk("vec_ctrl", reg_w_ctrl, vecs[i].e_ctrl);
         chk("vec_reg_w", reg_w, vecs[i].e_rw);
         chk("vec_w_data", w_data, vecs[i].e_data);
      end
      idle_inputs();

      // Long op without contention
      iss_valid = 1; iss_rd = 7; cycle();
      chk("lo_busy7_set", busy[7], 1);
      idle_inputs(); cycle();
      lu_valid = 1; lu_rd = 7; lu_data = 42; cycle();
      idle_inputs(); cycle();
      chk("lo_reg_w", reg_w, 7);
      chk("lo_w_data", w_data, 42);
      chk("lo_ctrl", reg_w_ctrl, 1);
      chk("lo_busy7_clr", busy[7], 0);

      // Priority and full FIFO
      for (int i = 1; i <= 5; i++) begin
         iss_valid = 1; iss_rd = 5'(i); cycle();
      end
      idle_inputs();
      for (int c = 0; c < 6; c++) begin
         pipe_valid = 1; pipe_rd = 5'(20 + c); pipe_data = 64'(c);
         lu_valid = 1;
         lu_rd    = (c < 4) ? 5'(c + 1) : 5'd5;
         lu_data  = (c < 4) ? 64'((c + 1) * 10) : 64'd50;
         cycle();
         chk("pf_pipe_reg_w", reg_w, 20 + c);
         if (c == 3) begin
            chk("pf_full_ready", lu_ready, 0);
            chk("pf_full_count", fifo_count, 4);
         end
      end
      pipe_valid = 0;
      cycle();
      chk("pf_pop1_rw", reg_w, 1); chk("pf_pop1_wd", w_data, 10); chk("pf_pop1_ctrl", reg_w_ctrl, 1);
      cycle();
      chk("pf_pop2_rw", reg_w, 2); chk("pf_pushpop_count", fifo_count, 3);
      lu_valid = 0;
      cycle(); chk("pf_pop3_rw", reg_w, 3); chk("pf_pop3_wd", w_data, 30);
      cycle(); chk("pf_pop4_rw", reg_w, 4); chk("pf_pop4_wd", w_data, 40);
      cycle(); chk("pf_pop5_rw", reg_w, 5); chk("pf_pop5_wd", w_data, 50);
      chk("pf_busy_empty", busy, 0);
      idle_inputs();

      // Simultaneous events
      iss_valid = 1; iss_rd = 9; cycle();
      idle_inputs(); lu_valid = 1; lu_rd = 9; lu_data = 99; cycle();
      idle_inputs(); iss_valid = 1; iss_rd = 9; cycle();
      chk("sim_pop_iss_rw", reg_w, 9);
      chk("sim_set_wins", busy[9], 1);
      idle_inputs(); lu_valid = 1; lu_rd = 9; lu_data = 98; cycle();
      idle_inputs(); cycle();
      chk("sim_busy9_clr", busy[9], 0);
      for (int i = 10; i <= 12; i++) begin
         iss_valid = 1; iss_rd = 5'(i); cycle();
      end
      idle_inputs();
      pipe_valid = 1; pipe_rd = 3; pipe_data = 64'h33;
      lu_valid = 1; lu_rd = 10; lu_data = 100; cycle();
      lu_rd = 11; lu_data = 110; cycle();
      chk("sim_count2", fifo_count, 2);
      pipe_valid = 0; lu_rd = 12; lu_data = 120; cycle();
      chk("sim_pushpop_count", fifo_count, 2);
      chk("sim_pushpop_rw", reg_w, 10);
      idle_inputs(); cycle(); cycle();
      iss_valid = 1; iss_rd = 0; cycle();
      chk("sim_iss0_busy", busy, 0);
      idle_inputs();

      // Asynchronous reset in the middle of a burst
      iss_valid = 1; iss_rd = 13; cycle();
      iss_rd = 14; cycle();
      iss_valid = 0;
      pipe_valid = 1; pipe_rd = 6; pipe_data = 64'h66;
      lu_valid = 1; lu_rd = 13; lu_data = 130; cycle();
      lu_rd = 14; lu_data = 140; cycle();
      chk("mid_pre_count", fifo_count, 2);
      idle_inputs();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Random soak with legal stimulus
      for (int n = 0; n < 10000; n++) begin
         if (!hold_prev) begin
            lu_valid = 0;
            if (pending.size() > 0 && $urandom_range(0, 2) != 0) begin
               idx      = $urandom_range(0, pending.size() - 1);
               lu_rd    = pending[idx];
               pending.delete(idx);
               lu_data  = {$urandom, $urandom};
               lu_valid = 1;
            end
         end
         iss_valid = 0;
         if ($urandom_range(0, 3) == 0) begin
            r = $urandom_range(0, 31);
            if (!busy_m[r]) begin
               iss_valid = 1;
               iss_rd    = 5'(r);
               if (r != 0) pending.push_back(5'(r));
            end
         end
         pipe_valid = ($urandom_range(0, 9) < 4);
         r = $urandom_range(0, 31);
         pipe_rd   = busy_m[r] ? 5'd0 : 5'(r);
         pipe_data = {$urandom, $urandom};
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
